reduction_feeder: RTL

Upstream sequencer that sits in front of the tile reduction accumulator. It owns the accumulator's init value, init strobe, operand bus and result bus. It accepts a job as a valid/ready stream of tile vectors. It packs the vectors into groups of PAR and issues one group per ISSUE cycle to the accumulator. After the last group it captures the reduced tile and returns it on a valid/ready output port.

---
 rtl/reduction_feeder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/reduction_feeder.sv
// reduction_feeder: sequencer in front of the tile reduction accumulator.
// Collects a job of tile vectors from a valid/ready stream, hands them to the
// accumulator PAR at a time during single ISSUE cycles, then captures the
// reduced tile and returns it on a valid/ready result port. No arithmetic here.
module reduction_feeder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned TILE  = 129,
   parameter int unsigned PAR   = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [TILE*WIDTH-1:0]       in_data_i,
   input  logic                        in_last_i,
   input  logic [TILE*WIDTH-1:0]       init_i,
   output logic [TILE*WIDTH-1:0]       set_reg_o,
   output logic                        acc_clr_o,
   output logic [PAR*TILE*WIDTH-1:0]   operand_o,
   input  logic [TILE*WIDTH-1:0]       reduction_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [TILE*WIDTH-1:0]       out_data_o,
   output logic [15:0]                 out_count_o,
   output logic                        busy_o
);

   localparam int unsigned VW = TILE * WIDTH;
   localparam int unsigned CW = $clog2(PAR + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_CLEAR  = 3'd2;
   localparam logic [2:0] S_GATHER = 3'd3;
   localparam logic [2:0] S_ISSUE  = 3'd4;
   localparam logic [2:0] S_WAIT   = 3'd5;
   localparam logic [2:0] S_OUT    = 3'd6;

   logic [2:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   last_q, last_d;
   logic [PAR-1:0][VW-1:0] slot_q, slot_d;
   logic [VW-1:0]          set_reg_q, set_reg_d;
   logic                   acc_clr_q, acc_clr_d;
   logic [VW-1:0]          out_data_q, out_data_d;
   logic [15:0]            out_count_q, out_count_d;

   // Next-state and datapath updates for the job sequencer
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      slot_d      = slot_q;
      set_reg_d   = set_reg_q;
      acc_clr_d   = 1'b0;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;

      case (state_q)
         S_IDLE: begin
            // The beat on the bus is only used to start the job, not consumed.
            if (in_valid_i) begin
               set_reg_d   = init_i;
               cnt_d       = '0;
               last_d      = 1'b0;
               out_count_d = '0;
               state_d     = S_SETUP;
            end
         end
         S_SETUP: begin
            // Init value has settled; raise the clear flop for the CLEAR cycle.
            acc_clr_d = 1'b1;
            state_d   = S_CLEAR;
         end
         S_CLEAR: begin
            state_d = S_GATHER;
         end
         S_GATHER: begin
            if (in_valid_i) begin
               for (int unsigned i = 0; i < PAR; i++) begin
                  if (cnt_q == CW'(i)) begin
                     slot_d[i] = in_data_i;
                  end
               end
               cnt_d = cnt_q + CW'(1);
               if (out_count_q != 16'hFFFF) begin
                  out_count_d = out_count_q + 16'd1;
               end
               if (in_last_i) begin
                  last_d = 1'b1;
               end
               // A full group and a last beat issue once together.
               if ((cnt_q == CW'(PAR - 1)) || in_last_i) begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            slot_d  = '0;
            cnt_d   = '0;
            state_d = last_q ? S_WAIT : S_GATHER;
         end
         S_WAIT: begin
            // Accumulator has absorbed the final group; its output is the result.
            out_data_d = reduction_i;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any job and holds the accumulator cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         last_q      <= 1'b0;
         slot_q      <= '0;
         set_reg_q   <= '0;
         acc_clr_q   <= 1'b1;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         slot_q      <= slot_d;
         set_reg_q   <= set_reg_d;
         acc_clr_q   <= acc_clr_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

   // Outputs; operands are forced to zero outside ISSUE since the accumulator
   // adds on every cycle.
   always_comb begin
      in_ready_o  = (state_q == S_GATHER);
      operand_o   = (state_q == S_ISSUE) ? slot_q : '0;
      out_valid_o = (state_q == S_OUT);
      busy_o      = (state_q != S_IDLE);
      set_reg_o   = set_reg_q;
      acc_clr_o   = acc_clr_q;
      out_data_o  = out_data_q;
      out_count_o = out_count_q;
   end

endmodule
